// File: rtl/clause_register_file_if.sv
// clause_register_file_if
//   Bus bundle for clause_register_file: write/maintenance controls, scan
//   start, and the streamed clause output.
//
//   Handshake: the scan side presents a clause by raising out_valid together
//   with out_clause_coefficients/out_clause_index. The clause is transferred
//   on a rising edge where out_valid && in_ready. While out_valid is high and
//   in_ready is low, data and index are held stable. out_valid never drops
//   without a transfer, except through reset.
//
//   Modports:
//     master : consumer/controller side (drives in_*, observes out_*)
//     slave  : clause_register_file side
//   Optional macro: CLAUSE_REG_PARITY_EN adds out_parity_error.
interface clause_register_file_if #(
  parameter int BIT_WIDTH = 8,
  parameter int NUM_VARS  = 4,
  parameter int DEPTH     = 16,
  parameter int AW        = $clog2(DEPTH)
) ();
  logic                          in_write_enable;
  logic [AW-1:0]                 in_write_address;
  logic [BIT_WIDTH*NUM_VARS-1:0] in_clause_coefficients;
  logic                          in_invalidate;
  logic                          in_clear_all;
  logic                          in_start_scan;
  logic                          in_ready;
  logic                          out_valid;
  logic [BIT_WIDTH*NUM_VARS-1:0] out_clause_coefficients;
  logic [AW-1:0]                 out_clause_index;
  logic                          out_scan_busy;
  logic                          out_scan_done;
  logic [AW:0]                   out_valid_count;
  logic [1:0]                    dbg_state;
`ifdef CLAUSE_REG_PARITY_EN
  logic                          out_parity_error;
`endif

  modport master (
`ifdef CLAUSE_REG_PARITY_EN
    input  out_parity_error,
`endif
    output in_write_enable, in_write_address, in_clause_coefficients,
           in_invalidate, in_clear_all, in_start_scan, in_ready,
    input  out_valid, out_clause_coefficients, out_clause_index,
           out_scan_busy, out_scan_done, out_valid_count, dbg_state
  );

  modport slave (
`ifdef CLAUSE_REG_PARITY_EN
    output out_parity_error,
`endif
    input  in_write_enable, in_write_address, in_clause_coefficients,
           in_invalidate, in_clear_all, in_start_scan, in_ready,
    output out_valid, out_clause_coefficients, out_clause_index,
           out_scan_busy, out_scan_done, out_valid_count, dbg_state
  );
endinterface

// File: rtl/clause_register_file.sv
// clause_register_file
//   Stores up to DEPTH clauses (NUM_VARS signed BIT_WIDTH-bit coefficients
//   each) with a per-entry valid bit, and streams the valid clauses out in
//   index order through a one-deep output slot when a scan is started.
//
//   Ports:
//     in_clk      : clock, rising edge
//     in_reset_n  : asynchronous active-low reset
//     bus (slave) : write/invalidate/clear controls, scan start, in_ready,
//                   out_valid/out_clause_coefficients/out_clause_index,
//                   out_scan_busy, out_scan_done, out_valid_count,
//                   dbg_state (FSM state for observation)
//   Optional macro: CLAUSE_REG_PARITY_EN stores an even-parity bit per entry
//   and reports out_parity_error alongside out_valid.
module clause_register_file #(
  parameter int BIT_WIDTH = 8,
  parameter int NUM_VARS  = 4,
  parameter int DEPTH     = 16,
  parameter int AW        = $clog2(DEPTH)
) (
  input logic                   in_clk,
  input logic                   in_reset_n,
  clause_register_file_if.slave bus
);
  localparam int          CW      = BIT_WIDTH * NUM_VARS;
  localparam logic [AW:0] PTR_END = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_DONE = 2'd2} state_t;

  logic [CW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [AW:0]      count_d;
  logic [AW:0]      count_q;
  state_t           state;
  logic [AW:0]      ptr;       // one extra bit so "past the last entry" is representable
  logic [AW-1:0]    ptr_idx;
  logic             out_valid_q;
  logic [CW-1:0]    out_data_q;
  logic [AW-1:0]    out_idx_q;
  logic             done_q;
  logic             slot_free;

  assign ptr_idx   = ptr[AW-1:0];
  assign slot_free = !out_valid_q || bus.in_ready;

  // Next valid vector: clear_all dominates, then write (sets valid even when
  // invalidate targets the same entry), then invalidate.
  always_comb begin
    valid_d = valid_q;
    if (bus.in_clear_all) begin
      valid_d = '0;
    end else if (bus.in_write_enable) begin
      valid_d[bus.in_write_address] = 1'b1;
    end else if (bus.in_invalidate) begin
      valid_d[bus.in_write_address] = 1'b0;
    end
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + (AW+1)'(valid_d[i]);
    end
  end

  // Clause storage carries no reset; only the valid bits qualify it.
  always_ff @(posedge in_clk) begin
    if (bus.in_write_enable) begin
      mem[bus.in_write_address] <= bus.in_clause_coefficients;
    end
  end

`ifdef CLAUSE_REG_PARITY_EN
  logic par_mem [DEPTH];
  logic par_err_q;

  always_ff @(posedge in_clk) begin
    if (bus.in_write_enable) begin
      par_mem[bus.in_write_address] <= ^bus.in_clause_coefficients;
    end
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      par_err_q <= 1'b0;
    end else if (state == S_SCAN && slot_free) begin
      if (ptr != PTR_END && valid_q[ptr_idx]) begin
        par_err_q <= (^mem[ptr_idx]) ^ par_mem[ptr_idx];
      end else begin
        par_err_q <= 1'b0;
      end
    end
  end

  assign bus.out_parity_error = par_err_q;
`endif

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state       <= S_IDLE;
      ptr         <= '0;
      valid_q     <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      done_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.in_start_scan) begin
            state <= S_SCAN;
            ptr   <= '0;
          end
        end
        S_SCAN: begin
          // Nothing moves while the presented clause is back-pressured.
          if (slot_free) begin
            if (ptr == PTR_END) begin
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
              state       <= S_DONE;
            end else begin
              // The clause is sampled here; later writes to this entry do
              // not disturb the presented copy.
              if (valid_q[ptr_idx]) begin
                out_valid_q <= 1'b1;
                out_data_q  <= mem[ptr_idx];
                out_idx_q   <= ptr_idx;
              end else begin
                out_valid_q <= 1'b0;
              end
              ptr <= ptr + PTR_ONE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.out_valid               = out_valid_q;
  assign bus.out_clause_coefficients = out_data_q;
  assign bus.out_clause_index        = out_idx_q;
  assign bus.out_scan_busy           = (state != S_IDLE);
  assign bus.out_scan_done           = done_q;
  assign bus.out_valid_count         = count_q;
  assign bus.dbg_state               = state;
endmodule

// File: tb/tb_clause_register_file.sv
module tb_clause_register_file;
  localparam int BW    = 8;
  localparam int NV    = 4;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int CW    = BW * NV;
  localparam int QW    = AW + CW;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clause_register_file_if #(.BIT_WIDTH(BW), .NUM_VARS(NV), .DEPTH(DEPTH), .AW(AW)) bus ();

  clause_register_file #(.BIT_WIDTH(BW), .NUM_VARS(NV), .DEPTH(DEPTH), .AW(AW)) dut (
    .in_clk     (clk),
    .in_reset_n (rst_n),
    .bus        (bus)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [CW-1:0]    model_mem [DEPTH];
  logic [DEPTH-1:0] model_valid;
  logic [QW-1:0]    exp_q[$];   // {index, coefficients} in expected stream order

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_write_enable        = 1'b0;
    bus.in_write_address       = '0;
    bus.in_clause_coefficients = '0;
    bus.in_invalidate          = 1'b0;
    bus.in_clear_all           = 1'b0;
    bus.in_start_scan          = 1'b0;
  endtask

  // One maintenance operation lasting one edge; the model follows the
  // documented priority clear_all > write > invalidate.
  task automatic apply_op(input logic clr, input logic we, input logic inv,
                          input logic [AW-1:0] a, input logic [CW-1:0] d);
    bus.in_clear_all           = clr;
    bus.in_write_enable        = we;
    bus.in_invalidate          = inv;
    bus.in_write_address       = a;
    bus.in_clause_coefficients = d;
    tick();
    if (we) model_mem[a] = d;
    if (clr)       model_valid    = '0;
    else if (we)   model_valid[a] = 1'b1;
    else if (inv)  model_valid[a] = 1'b0;
    idle_inputs();
    check("valid_count", bus.out_valid_count, $countones(model_valid));
  endtask

  task automatic build_expected();
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++)
      if (model_valid[i]) exp_q.push_back({AW'(i), model_mem[i]});
  endtask

  // Runs one scan. ready_mode: 0 = always ready, 1 = random, 2 = hold ready
  // low for the first four presented cycles. n counts edges after the start edge.
  task automatic run_scan(input int ready_mode, input int budget,
                          output int first_n, output int last_n, output int done_n);
    int  n;
    int  held;
    bit  r;
    bit  seen;
    first_n = -1; last_n = -1; done_n = -1;
    held = 0; seen = 0;
    bus.in_start_scan = 1'b1;
    tick();
    bus.in_start_scan = 1'b0;
    n = 0;
    check("busy_after_start", bus.out_scan_busy, 1);
    while (n < budget) begin
      if (bus.out_scan_done) begin
        done_n = n;
        seen   = 1;
        break;
      end
      if (bus.out_valid) begin
        if (first_n < 0) first_n = n;
        last_n = n;
        check("clause_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          check("scan_index", bus.out_clause_index, exp_q[0][QW-1:CW]);
          check("scan_data", bus.out_clause_coefficients, exp_q[0][CW-1:0]);
        end
`ifdef CLAUSE_REG_PARITY_EN
        check("parity_error", bus.out_parity_error, 0);
`endif
      end
      case (ready_mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: begin
          if (bus.out_valid && held < 4) begin
            r = 1'b0;
            held++;
          end else begin
            r = 1'b1;
          end
        end
      endcase
      bus.in_ready = r;
      if (bus.out_valid && r && exp_q.size() != 0) void'(exp_q.pop_front());
      tick();
      n++;
    end
    bus.in_ready = 1'b1;
    check("done_within_budget", seen, 1);
    check("all_clauses_delivered", exp_q.size(), 0);
    tick();
    check("done_one_cycle", bus.out_scan_done, 0);
    check("idle_after_done", bus.out_scan_busy, 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int f, l, d, n, dn;
    bit seen;
    idle_inputs();
    bus.in_ready = 1'b1;
    model_valid  = '0;

    // Reset state
    tick();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_clause_coefficients, 0);
    check("rst_out_index", bus.out_clause_index, 0);
    check("rst_busy", bus.out_scan_busy, 0);
    check("rst_done", bus.out_scan_done, 0);
    check("rst_count", bus.out_valid_count, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Three consecutive clauses 7,8,9
    apply_op(0, 1, 0, 4'd0, 32'd7);
    apply_op(0, 1, 0, 4'd1, 32'd8);
    apply_op(0, 1, 0, 4'd2, 32'd9);
    build_expected();
    run_scan(0, 60, f, l, d);
    check("t1_first_latency", f, 1);
    check("t1_back_to_back", l - f + 1, 3);
    check("t1_done_cycle", d, DEPTH + 1);
    check("t1_count", bus.out_valid_count, 3);

    // Single entry 5
    apply_op(1, 0, 0, 4'd0, 32'd0);
    apply_op(0, 1, 0, 4'd5, 32'h0A0B0C0D);
    build_expected();
    run_scan(0, 60, f, l, d);
    check("t2_first_latency", f, 6);
    check("t2_done_cycle", d, DEPTH + 1);

    // Backpressure on entries 0..3
    apply_op(1, 0, 0, 4'd0, 32'd0);
    for (int i = 0; i < 4; i++) apply_op(0, 1, 0, AW'(i), $urandom());
    build_expected();
    run_scan(2, 80, f, l, d);
    check("t3_first_latency", f, 1);

    // Write to the presented entry must not change the presented clause
    apply_op(1, 0, 0, 4'd0, 32'd0);
    apply_op(0, 1, 0, 4'd3, 32'h11223344);
    bus.in_ready      = 1'b0;
    bus.in_start_scan = 1'b1;
    tick();
    bus.in_start_scan = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("t4_presented_valid", bus.out_valid, 1);
    check("t4_presented_index", bus.out_clause_index, 3);
    check("t4_presented_data", bus.out_clause_coefficients, 32'h11223344);
    apply_op(0, 1, 0, 4'd3, 32'h55667788);
    check("t4_snapshot_valid", bus.out_valid, 1);
    check("t4_snapshot_data", bus.out_clause_coefficients, 32'h11223344);
    bus.in_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (bus.out_scan_done) seen = 1;
    end
    check("t4_first_scan_done", seen, 1);
    tick();
    build_expected();
    run_scan(0, 60, f, l, d);
    check("t4_second_latency", f, 4);

    // Reset mid-scan
    for (int i = 0; i < 8; i++) apply_op(0, 1, 0, AW'(i), $urandom());
    bus.in_ready      = 1'b0;
    bus.in_start_scan = 1'b1;
    tick();
    bus.in_start_scan = 1'b0;
    tick(); tick(); tick();
    check("t5_pre_reset_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    model_valid = '0;
    check("t5_rst_valid", bus.out_valid, 0);
    check("t5_rst_data", bus.out_clause_coefficients, 0);
    check("t5_rst_index", bus.out_clause_index, 0);
    check("t5_rst_busy", bus.out_scan_busy, 0);
    check("t5_rst_done", bus.out_scan_done, 0);
    check("t5_rst_count", bus.out_valid_count, 0);
    tick(); tick();
    rst_n        = 1'b1;
    bus.in_ready = 1'b1;
    dn = 0; n = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (bus.out_scan_done) dn++;
      if (bus.out_valid) n++;
    end
    check("t5_no_done_after_abort", dn, 0);
    check("t5_no_valid_after_abort", n, 0);

    // Empty scan
    build_expected();
    run_scan(0, 60, f, l, d);
    check("t6_never_valid", f, -1);
    check("t6_done_cycle", d, DEPTH + 1);

    // Priority corners
    apply_op(1, 1, 0, 4'd2, 32'hDEADBEEF);
    check("t6_clear_beats_write", bus.out_valid_count, 0);
    apply_op(0, 1, 1, 4'd9, 32'h01020304);
    check("t7_write_beats_inval", bus.out_valid_count, 1);
    apply_op(0, 0, 1, 4'd9, 32'h0);
    check("t7_inval", bus.out_valid_count, 0);

    // Randomized fill + scan rounds with random backpressure
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 14; k++)
        apply_op(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), AW'($urandom_range(0, DEPTH-1)), $urandom());
      build_expected();
      run_scan(1, 300, f, l, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clause_register_file.md
Name: clause_register_file

Overview:
Parametrised successor to the single-entry clause register. Stores up to DEPTH clauses, each NUM_VARS signed coefficients of BIT_WIDTH bits, with a per-entry valid bit. A scan engine streams the valid clauses out in index order over a valid/ready handshake, feeding the MCMC constraint-evaluation datapath.

Parameters:
BIT_WIDTH, 8, width of one integer-variable coefficient
NUM_VARS, 4, coefficients per clause
DEPTH, 16, number of clause entries (power of two, >=2)
AW, $clog2(DEPTH), address width (derived)

Ports:
in_clk  input  1  clock, rising edge
in_reset_n  input  1  asynchronous active-low reset
in_write_enable  input  1  write in_clause_coefficients to in_write_address, set that entry valid
in_write_address  input  AW  write index
in_clause_coefficients  input  BIT_WIDTH*NUM_VARS  clause data; coefficient k in bits [k*BIT_WIDTH +: BIT_WIDTH]
in_invalidate  input  1  clear valid bit of in_write_address
in_clear_all  input  1  clear all valid bits
in_start_scan  input  1  start a scan (accepted only in IDLE)
in_ready  input  1  consumer accepts out_clause_coefficients
out_valid  output  1  output slot holds a clause
out_clause_coefficients  output  BIT_WIDTH*NUM_VARS  presented clause
out_clause_index  output  AW  index of presented clause
out_scan_busy  output  1  FSM not in IDLE
out_scan_done  output  1  one-cycle pulse at scan end
out_valid_count  output  AW+1  number of valid entries

Behaviour:
- Reset (async, in_reset_n=0): all valid bits 0, FSM IDLE, out_valid=0, out_clause_coefficients=0, out_clause_index=0, out_scan_busy=0, out_scan_done=0, out_valid_count=0. Storage data need not be reset. Reset mid-scan aborts the scan; no done pulse.
- Writes: synchronous, take effect at the rising edge; allowed in any state. Priority: in_clear_all > in_write_enable > in_invalidate. in_write_enable with in_invalidate on the same cycle: the entry ends valid with the new data.
- out_valid_count: registered; equals the popcount of the valid bits after the edge's update.
- FSM states and transitions:
  - IDLE -> SCAN on in_start_scan; pointer ptr := 0.
  - SCAN: each cycle the slot is free (out_valid=0, or out_valid && in_ready), examine entry ptr.
    - If valid: load data and index into the output regs, set out_valid, ptr++.
    - If invalid: leave out_valid as it was (0 if the slot was just consumed), ptr++.
    - One entry examined per cycle. Latency from start to first out_valid is 1 + the number of leading invalid entries.
  - When ptr has passed DEPTH-1 and the slot has drained (out_valid=0): -> DONE.
  - DONE: out_scan_done=1 for exactly one cycle, then -> IDLE.
  - Zero-valid scan: DEPTH cycles in SCAN, then the done pulse; out_valid never asserts.
- Handshake: out_clause_coefficients and out_clause_index are stable while out_valid && !in_ready. A transfer is a cycle with out_valid && in_ready. Full throughput is one clause per cycle when all entries are valid and in_ready is held high.
- Snapshot rule: data is sampled when loaded into the output slot. A write to an already-loaded entry does not alter the presented value. A write to an entry not yet reached is seen by the scan. in_clear_all during SCAN makes the remaining entries invalid but does not drop the presented clause.
- in_start_scan outside IDLE: ignored.

Optional Feature:
CLAUSE_REG_PARITY_EN
- Defined: each entry stores an even-parity bit computed on write. Adds output port out_parity_error (1 bit), registered alongside out_valid: high when the presented clause's recomputed parity mismatches the stored bit. Reset value 0.
- Undefined: no parity storage and no out_parity_error port.

Test Plan:
- Reset, write entries 0,1,2 with 7,8,9 (coefficient 0), start scan, in_ready=1 -> out_valid for 3 consecutive cycles with indices 0,1,2 and data 7,8,9; out_scan_done pulse; out_valid_count=3.
- Write only entry 5 = 0x0A0B0C0D, scan -> first out_valid 6 cycles after start, index 5, then done.
- Backpressure: entries 0..3 valid, in_ready low 4 cycles after first out_valid -> index 0 and its data held stable; order 0,1,2,3 preserved; no loss or duplication.
- Write entry 3 while index 3 is presented -> presented data unchanged; a second scan returns the new value.
- Assert in_reset_n=0 mid-scan -> outputs go to reset values immediately, no out_scan_done, out_valid_count=0.
- Empty file, in_start_scan -> out_valid stays 0, done pulse after DEPTH+1 cycles; in_clear_all with write on same edge -> out_valid_count=0.
